dt_integrator: RTL and testbench
================================

# dt_integrator

Reconstructs a temperature trajectory T (Q7.0) by integrating a stream of rate samples dT (Q7.0). This is the inverse path of the dT estimator. It sits downstream of any dT source (the estimator, or an external dT feed when DT_MODE=0) and produces a predicted T for control and logging. Internals:
- Q8.7 accumulator with a programmable step gain of 2^-k.
- Symmetric-bound saturation.
- Seeded start via INIT.
- Staleness detection when the dT stream stops.

## Interface
Parameters:
- ACC_W, 16, accumulator width (signed Q8.7); fixed at 16 for this revision.
- CNT_W, 8, idle-cycle counter width.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- init  in  1  1-cycle pulse; loads t_seed into the accumulator
- t_seed  in  8  signed Q7.0 start value
- dt_in  in  8  signed Q7.0 rate sample
- dt_valid  in  1  dt_in qualifier; one sample accepted per cycle while high
- k_dt  in  3  step gain divider 2^k (0..7)
- t_min  in  8  signed Q7.0 lower bound
- t_max  in  8  signed Q7.0 upper bound
- timeout  in  CNT_W  idle cycles before STALE; 0 disables
- T_out  out  8  signed Q7.0 integrated value (registered)
- t_valid  out  1  1-cycle strobe per accepted sample
- stale  out  1  level; high in STALE
- sat_hi  out  1  last accepted sample clamped at t_max
- sat_lo  out  1  last accepted sample clamped at t_min

## Operation
- States: IDLE (reset), TRACK, STALE.
- IDLE: dt_valid is ignored. init loads the seed and moves to TRACK.
- Seed load (init, any state): acc = clamp(t_seed) <<< 7. Also:
  - T_out = clamp(t_seed).
  - idle counter = 0.
  - sat_hi, sat_lo and stale are cleared; t_valid = 0 (no spike).
  - Next state is TRACK.
- init has priority over dt_valid in the same cycle; that dT sample is dropped.
- Accept (TRACK or STALE, dt_valid=1, init=0):
  - step = (sext16(dt_in) <<< 7) >>> k_dt, arithmetic shift.
  - sum = acc + step, computed in 17 bits with no wrap.
  - acc = clamp(sum, t_min<<<7, t_max<<<7).
  - t_valid = 1, counter = 0, next state TRACK, stale = 0.
- Clamp flags on an accepted sample: sat_hi = (sum > hi), sat_lo = (sum < lo). The flags hold until the next accepted sample or init.
- Degenerate bounds: if t_min > t_max, both bounds equal t_min.
- Output conversion: T_out = (acc < 0 ? acc + 127 : acc) >>> 7, i.e. truncation toward zero. It is registered together with acc.
- TRACK, no sample:
  - The counter increments, saturating at all-ones.
  - When counter+1 == timeout (timeout ≠ 0), the block moves to STALE and stale = 1.
  - acc and T_out are unchanged.
- STALE: acc is frozen, the counter is held, and stale = 1 until a sample is accepted or init arrives.
- Changing t_min/t_max does not re-clamp the held acc; the new bounds apply from the next accepted sample.

## Timing
- Reset values (asynchronous, immediate): state IDLE, acc=0, T_out=0, t_valid=0, stale=0, sat_hi=0, sat_lo=0, counter=0.
- Latency: a sample on edge n appears on T_out, t_valid and sat_* after edge n (visible in cycle n+1). That is 1 cycle.
- Throughput: 1 sample per cycle; back-to-back dt_valid is supported with no bubbles.
- t_valid is high for exactly one cycle per accepted sample and never on init.
- Stale entry: with timeout=N, if the last sample arrives at edge 0 with no samples at edges 1..N, stale rises after edge N.
- STALE exit: an accepted sample clears stale on the same edge that updates T_out.
- rst asserted mid-stream: all outputs clear without waiting for an edge. After release, the block stays in IDLE until init.

## Test plan
- Basic integration:
  - Stimulus: rst, then init t_seed=20 with k_dt=0, t_min=-100, t_max=100; then dt_in=5 valid for 4 cycles.
  - Response: T_out 25, 30, 35, 40; four t_valid strobes.
- Gain and sign:
  - Stimulus: seed 0, k_dt=2, dt_in=+1 ×4.
  - Response: acc 32/64/96/128, T_out 0, 0, 0, 1.
  - Stimulus: re-init 0, dt_in=-1 ×4.
  - Response: T_out 0, 0, 0, -1.
- Saturation:
  - Stimulus: t_max=50, seed 45, dt_in=10.
  - Response: T_out=50, sat_hi=1.
  - Stimulus: then dt_in=-3.
  - Response: T_out=47, sat_hi=0.
  - Stimulus: seed 90 with t_max=50.
  - Response: T_out=50 after init, t_valid=0.
- Stale:
  - Stimulus: timeout=3, one sample, then dt_valid low for 3 cycles.
  - Response: stale=1 after the 3rd idle edge, T_out unchanged.
  - Stimulus: then dt_in=2.
  - Response: stale=0 and T_out+2 on the same cycle. With timeout=0 and 300 idle cycles, stale stays 0.
- Init collision:
  - Stimulus: init with t_seed=-10 and dt_valid with dt_in=50 in the same cycle, while sat_lo=1.
  - Response: T_out=-10, t_valid=0, sat_lo=0, sample dropped.
- Async reset:
  - Stimulus: assert rst mid-stream between edges.
  - Response: T_out=0 and stale=0 immediately. After release, dt_valid pulses produce no t_valid until init.

Source files
------------

// File: rtl/dt_integrator.sv
// dt_integrator: rebuilds a Q7.0 temperature trajectory by integrating signed
// Q7.0 rate samples in a Q8.7 accumulator. The step gain is 2^-k_dt. The result
// saturates to [t_min, t_max] and the block reports staleness when samples stop.
// Latency: 1 cycle from an accepted sample to T_out/t_valid/sat_*. No backpressure;
// one sample per cycle is accepted while dt_valid is high in TRACK/STALE.
// Ports: clk/rst (async active-high), init + t_seed (seed load), dt_in/dt_valid
// (rate stream), k_dt (gain shift), t_min/t_max (bounds), timeout (idle limit, 0=off),
// T_out/t_valid (result + strobe), stale (level), sat_hi/sat_lo (last clamp direction).
module dt_integrator #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init,
  input  logic signed [7:0]       t_seed,
  input  logic signed [7:0]       dt_in,
  input  logic                    dt_valid,
  input  logic        [2:0]       k_dt,
  input  logic signed [7:0]       t_min,
  input  logic signed [7:0]       t_max,
  input  logic        [CNT_W-1:0] timeout,
  output logic signed [7:0]       T_out,
  output logic                    t_valid,
  output logic                    stale,
  output logic                    sat_hi,
  output logic                    sat_lo
);

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_STALE} state_t;

  localparam logic signed [ACC_W-1:0] RND = ACC_W'(127);

  state_t                   state_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [7:0]        t_out_q;
  logic                     t_valid_q;
  logic                     stale_q;
  logic                     sat_hi_q;
  logic                     sat_lo_q;
  logic        [CNT_W-1:0]  cnt_q;

  logic signed [7:0]        hi_b;
  logic signed [7:0]        seed_c;
  logic signed [ACC_W-1:0]  seed_acc_d;
  logic signed [ACC_W-1:0]  dt_ext;
  logic signed [ACC_W-1:0]  dt_sh;
  logic signed [ACC_W-1:0]  step;
  logic signed [ACC_W:0]    sum;
  logic signed [ACC_W:0]    hi_w;
  logic signed [ACC_W:0]    lo_w;
  logic signed [ACC_W:0]    clamp_w;
  logic                     sum_hi;
  logic                     sum_lo;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [7:0]        t_out_d;
  logic        [CNT_W:0]    cnt_p1;
  logic        [CNT_W-1:0]  cnt_d;
  logic                     to_stale;

  // Q8.7 -> Q7.0 with truncation toward zero: negative values are biased by
  // 127 before the arithmetic shift so they round up instead of down.
  function automatic logic signed [7:0] to_q70(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] r;
    r = a[ACC_W-1] ? (a + RND) : a;
    return 8'(r >>> 7);
  endfunction

  always_comb begin
    // Inverted bounds collapse onto t_min.
    hi_b = (t_min > t_max) ? t_min : t_max;

    if (t_seed > hi_b)       seed_c = hi_b;
    else if (t_seed < t_min) seed_c = t_min;
    else                     seed_c = t_seed;
    seed_acc_d = {{(ACC_W-15){seed_c[7]}}, seed_c, 7'd0};

    dt_ext = {{(ACC_W-8){dt_in[7]}}, dt_in};
    dt_sh  = dt_ext <<< 7;
    step   = dt_sh >>> k_dt;

    // One extra bit so the sum cannot wrap before it is clamped.
    sum  = {acc_q[ACC_W-1], acc_q} + {step[ACC_W-1], step};
    hi_w = {{(ACC_W-14){hi_b[7]}}, hi_b, 7'd0};
    lo_w = {{(ACC_W-14){t_min[7]}}, t_min, 7'd0};

    sum_hi = (sum > hi_w);
    sum_lo = (sum < lo_w);
    if (sum_hi)      clamp_w = hi_w;
    else if (sum_lo) clamp_w = lo_w;
    else             clamp_w = sum;
    acc_d   = ACC_W'(clamp_w);
    t_out_d = to_q70(acc_d);

    // Compare against the unsaturated increment so a saturated counter
    // never re-matches the timeout.
    cnt_p1   = {1'b0, cnt_q} + (CNT_W+1)'(1);
    cnt_d    = (&cnt_q) ? cnt_q : cnt_p1[CNT_W-1:0];
    to_stale = (timeout != '0) && (cnt_p1 == {1'b0, timeout});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      t_out_q   <= '0;
      t_valid_q <= 1'b0;
      stale_q   <= 1'b0;
      sat_hi_q  <= 1'b0;
      sat_lo_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      t_valid_q <= 1'b0;
      if (init) begin
        // Seed wins over a coincident sample; that sample is dropped.
        state_q  <= S_TRACK;
        acc_q    <= seed_acc_d;
        t_out_q  <= seed_c;
        stale_q  <= 1'b0;
        sat_hi_q <= 1'b0;
        sat_lo_q <= 1'b0;
        cnt_q    <= '0;
      end else if (state_q != S_IDLE) begin
        if (dt_valid) begin
          state_q   <= S_TRACK;
          acc_q     <= acc_d;
          t_out_q   <= t_out_d;
          t_valid_q <= 1'b1;
          stale_q   <= 1'b0;
          sat_hi_q  <= sum_hi;
          sat_lo_q  <= sum_lo;
          cnt_q     <= '0;
        end else if (state_q == S_TRACK) begin
          cnt_q <= cnt_d;
          if (to_stale) begin
            state_q <= S_STALE;
            stale_q <= 1'b1;
          end
        end
      end
    end
  end

  assign T_out   = t_out_q;
  assign t_valid = t_valid_q;
  assign stale   = stale_q;
  assign sat_hi  = sat_hi_q;
  assign sat_lo  = sat_lo_q;

endmodule

// File: tb/tb_dt_integrator.sv
// Bench for dt_integrator: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against an integer reference model.
module tb_dt_integrator;

  logic              clk = 1'b0;
  logic              rst;
  logic              init;
  logic signed [7:0] t_seed;
  logic signed [7:0] dt_in;
  logic              dt_valid;
  logic        [2:0] k_dt;
  logic signed [7:0] t_min;
  logic signed [7:0] t_max;
  logic        [7:0] timeout;
  logic signed [7:0] T_out;
  logic              t_valid;
  logic              stale;
  logic              sat_hi;
  logic              sat_lo;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  dt_integrator #(.ACC_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .init(init), .t_seed(t_seed), .dt_in(dt_in),
    .dt_valid(dt_valid), .k_dt(k_dt), .t_min(t_min), .t_max(t_max),
    .timeout(timeout), .T_out(T_out), .t_valid(t_valid), .stale(stale),
    .sat_hi(sat_hi), .sat_lo(sat_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- reference model (value scaled by 128) ----------------
  int m_acc = 0;
  int m_cnt = 0;
  bit m_tv = 0, m_stale = 0, m_hi = 0, m_lo = 0, m_seeded = 0;
  int m_lo_b, m_hi_b, m_sum;

  function automatic int floordiv(input int x, input int d);
    int q;
    q = x / d;
    if ((x % d) != 0 && x < 0) q = q - 1;
    return q;
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_acc = 0; m_cnt = 0; m_tv = 0; m_stale = 0;
      m_hi = 0; m_lo = 0; m_seeded = 0;
    end else begin
      m_lo_b = int'(t_min);
      m_hi_b = (int'(t_min) > int'(t_max)) ? int'(t_min) : int'(t_max);
      m_tv = 0;
      if (init) begin
        m_acc = 128 * clampi(int'(t_seed), m_lo_b, m_hi_b);
        m_cnt = 0; m_hi = 0; m_lo = 0; m_stale = 0; m_seeded = 1;
      end else if (m_seeded && dt_valid) begin
        m_sum = m_acc + floordiv(128 * int'(dt_in), 1 << k_dt);
        m_hi  = (m_sum > 128 * m_hi_b);
        m_lo  = (m_sum < 128 * m_lo_b);
        m_acc = clampi(m_sum, 128 * m_lo_b, 128 * m_hi_b);
        m_tv = 1; m_cnt = 0; m_stale = 0;
      end else if (m_seeded && !m_stale) begin
        if (timeout != 0 && m_cnt + 1 == int'(timeout)) m_stale = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
  end

  // Every-cycle comparison against the model; integer division truncates
  // toward zero, which is exactly the T_out conversion rule.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp T_out",   int'(T_out),   m_acc / 128);
      chk("cmp t_valid", int'(t_valid), int'(m_tv));
      chk("cmp stale",   int'(stale),   int'(m_stale));
      chk("cmp sat_hi",  int'(sat_hi),  int'(m_hi));
      chk("cmp sat_lo",  int'(sat_lo),  int'(m_lo));
    end
  end

  initial begin
    rst = 1'b1; init = 1'b0; t_seed = '0; dt_in = '0; dt_valid = 1'b0;
    k_dt = '0; t_min = -8'sd100; t_max = 8'sd100; timeout = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset T_out", int'(T_out), 0);
    chk("reset stale", int'(stale), 0);
    rst = 1'b0;
    cyc();

    // Basic integration
    init = 1'b1; t_seed = 8'sd20; cyc(); init = 1'b0;
    chk("seed T_out", int'(T_out), 20);
    chk("seed t_valid", int'(t_valid), 0);
    dt_valid = 1'b1; dt_in = 8'sd5;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("basic T_out", int'(T_out), 25 + 5 * i);
      chk("basic t_valid", int'(t_valid), 1);
    end
    dt_valid = 1'b0;

    // Gain and sign, k=2
    k_dt = 3'd2; init = 1'b1; t_seed = 8'sd0; cyc(); init = 1'b0;
    dt_valid = 1'b1; dt_in = 8'sd1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("gain pos T_out", int'(T_out), (i == 3) ? 1 : 0);
    end
    dt_valid = 1'b0; init = 1'b1; t_seed = 8'sd0; cyc(); init = 1'b0;
    dt_valid = 1'b1; dt_in = -8'sd1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("gain neg T_out", int'(T_out), (i == 3) ? -1 : 0);
    end
    dt_valid = 1'b0;

    // Saturation
    k_dt = 3'd0; t_max = 8'sd50; init = 1'b1; t_seed = 8'sd45; cyc(); init = 1'b0;
    dt_valid = 1'b1; dt_in = 8'sd10; cyc();
    chk("sat T_out", int'(T_out), 50);
    chk("sat sat_hi", int'(sat_hi), 1);
    dt_in = -8'sd3; cyc();
    chk("unsat T_out", int'(T_out), 47);
    chk("unsat sat_hi", int'(sat_hi), 0);
    dt_valid = 1'b0; init = 1'b1; t_seed = 8'sd90; cyc(); init = 1'b0;
    chk("seed clamp T_out", int'(T_out), 50);
    chk("seed clamp t_valid", int'(t_valid), 0);

    // Stale entry and exit
    timeout = 8'd3; dt_valid = 1'b1; dt_in = -8'sd5; cyc(); dt_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("stale level", int'(stale), (i == 3) ? 1 : 0);
      chk("stale T_out", int'(T_out), 45);
    end
    dt_valid = 1'b1; dt_in = 8'sd2; cyc(); dt_valid = 1'b0;
    chk("stale exit", int'(stale), 0);
    chk("stale exit T_out", int'(T_out), 47);
    timeout = 8'd0;
    repeat (300) cyc();
    chk("timeout0 stale", int'(stale), 0);

    // Init collision while sat_lo is set
    t_min = -8'sd20; t_max = 8'sd100; init = 1'b1; t_seed = -8'sd15; cyc(); init = 1'b0;
    dt_valid = 1'b1; dt_in = -8'sd10; cyc();
    chk("coll pre sat_lo", int'(sat_lo), 1);
    chk("coll pre T_out", int'(T_out), -20);
    init = 1'b1; t_seed = -8'sd10; dt_in = 8'sd50; cyc(); init = 1'b0; dt_valid = 1'b0;
    chk("coll T_out", int'(T_out), -10);
    chk("coll t_valid", int'(t_valid), 0);
    chk("coll sat_lo", int'(sat_lo), 0);
    cyc();
    chk("coll dropped", int'(T_out), -10);

    // Async reset mid-stream from STALE
    timeout = 8'd2; dt_valid = 1'b1; dt_in = 8'sd3; cyc(); cyc(); dt_valid = 1'b0;
    cyc(); cyc();
    chk("pre-rst stale", int'(stale), 1);
    #2 rst = 1'b1;
    #1;
    chk("async rst T_out", int'(T_out), 0);
    chk("async rst stale", int'(stale), 0);
    @(negedge clk);
    rst = 1'b0; dt_valid = 1'b1; dt_in = 8'sd7;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post-rst t_valid", int'(t_valid), 0);
    end
    dt_valid = 1'b0; init = 1'b1; t_seed = 8'sd7; cyc(); init = 1'b0;
    chk("post-rst seed", int'(T_out), 7);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      init     = ($urandom_range(0, 39) == 0);
      t_seed   = 8'($urandom);
      dt_in    = 8'($urandom);
      k_dt     = 3'($urandom);
      case ((i / 500) % 3)
        0:       dt_valid = ($urandom_range(0, 3) != 0);
        1:       dt_valid = ($urandom_range(0, 7) == 0);
        default: dt_valid = 1'b1;
      endcase
      if ($urandom_range(0, 49) == 0) begin
        t_min = 8'($urandom);
        t_max = 8'($urandom);
      end
      if ($urandom_range(0, 99) == 0) timeout = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 599) == 0) begin
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
